// File: rtl/operand_loader.sv
// Two-operand loader for a downstream adder: debounced load/clear buttons
// drive a LOAD_A -> LOAD_B -> READY sequencer with registered operand outputs.

module operand_loader_deb #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          lvl, lvl_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      lvl       <= 1'b0;
      lvl_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      lvl_q     <= lvl;
      if (sync_pipe[1] != lvl) begin
        if (cnt == CNT_MAX) begin
          lvl <= sync_pipe[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level only; releases stay silent.
  assign pulse = lvl & ~lvl_q;
endmodule

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       valid,
  output logic [1:0] stage
);
  localparam int NUM_BTN = 2;
  localparam int BTN_LOAD = 0;
  localparam int BTN_CLR  = 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  state_t             state;

  assign btn_raw = {btn_clear, btn_load};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    operand_loader_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_raw[i]),
      .pulse (btn_pulse[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      op_a  <= '0;
      op_b  <= '0;
      valid <= 1'b0;
    end else if (btn_pulse[BTN_CLR]) begin
      // Clear beats a coincident load.
      state <= LOAD_A;
      op_a  <= '0;
      op_b  <= '0;
      valid <= 1'b0;
    end else if (btn_pulse[BTN_LOAD]) begin
      case (state)
        LOAD_A: begin
          op_a  <= sw;
          state <= LOAD_B;
        end
        LOAD_B: begin
          op_b  <= sw;
          valid <= 1'b1;
          state <= READY;
        end
        READY: begin
          op_a  <= sw;
          valid <= 1'b0;
          state <= LOAD_B;
        end
        default: begin
          state <= LOAD_A;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign stage = state;
endmodule
